comp1_fifo_slave: RTL and testbench



---
 rtl/comp1_fifo_slave_pkg.sv | 15 +
 rtl/comp1_fifo_slave_mem.sv | 68 ++++++
 rtl/comp1_fifo_slave.sv | 145 ++++++++++++++
 tb/tb_comp1_fifo_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/comp1_fifo_slave_pkg.sv
// comp1_fifo_slave_pkg: shared FSM state type and default constants for the
// comp1 FIFO slave and its storage sub-module.
package comp1_fifo_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } comp1_fifo_slave_state_e;

  localparam int COMP1_DATA_W_DEF   = 32;
  localparam int COMP1_WAIT_CYC_MAX = 15;
  localparam int COMP1_WAIT_CNT_W   = 4;

endpackage

// File: rtl/comp1_fifo_slave_mem.sv
// comp1_fifo_slave_mem: FIFO storage with write/read pointers, an explicit
// occupancy counter and full/empty decode. The caller never asserts push and
// pop together, and only asserts them for requests that will succeed.
module comp1_fifo_slave_mem
  import comp1_fifo_slave_pkg::*;
#(
  parameter int DATA_W = COMP1_DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      level_d  = level_q + LVL_W'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d  = level_q - LVL_W'(1);
    end
  end

  // Pointer and level registers; reset empties the FIFO logically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array is deliberately not reset; stale contents are unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/comp1_fifo_slave.sv
// comp1_fifo_slave: valid/ready bus responder backed by a FIFO. Writes push,
// reads pop; overflow/underflow reported on err alongside the ready pulse.
// Optional wait states are built only when COMP1_FIFO_SLAVE_WAIT_EN is
// defined; otherwise WAIT_CYC is ignored and every request answers in 1 cycle.
module comp1_fifo_slave
  import comp1_fifo_slave_pkg::*;
#(
  parameter int DATA_W   = COMP1_DATA_W_DEF,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  output logic                   ready,
  input  logic                   write,
  input  logic [DATA_W-1:0]      data_wr,
  output logic [DATA_W-1:0]      data_rd,
  output logic                   err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("comp1_fifo_slave: DEPTH must be a power of two and at least 2");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > COMP1_WAIT_CYC_MAX) begin : g_bad_wait_cyc
    $error("comp1_fifo_slave: WAIT_CYC out of range 0..15");
  end

  comp1_fifo_slave_state_e state_q, state_d;
  logic [DATA_W-1:0]       data_rd_q, data_rd_d;
  logic                    err_q, err_d;

  logic [DATA_W-1:0]       head_data;
  logic                    fifo_full, fifo_empty;
  logic                    commit, push, pop;

`ifdef COMP1_FIFO_SLAVE_WAIT_EN
  localparam logic [COMP1_WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYC > 0) ? COMP1_WAIT_CNT_W'(WAIT_CYC - 1) : '0;
  logic [COMP1_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Next-state logic plus capture of the response on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    data_rd_d = '0;
    err_d     = 1'b0;
`ifdef COMP1_FIFO_SLAVE_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid) begin
`ifdef COMP1_FIFO_SLAVE_WAIT_EN
          if (WAIT_CYC == 0) begin
            state_d = RESP;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
`else
          state_d = RESP;
`endif
        end
      end
`ifdef COMP1_FIFO_SLAVE_WAIT_EN
      WAIT: begin
        if (!valid) begin
          state_d = IDLE;
        end else if (wait_cnt_q == '0) begin
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - COMP1_WAIT_CNT_W'(1);
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RESP && state_q != RESP) begin
      if (write) begin
        err_d = fifo_full;
      end else if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        data_rd_d = head_data;
      end
    end
  end

  // State and response registers; an in-flight request is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_rd_q <= data_rd_d;
      err_q     <= err_d;
    end
  end

`ifdef COMP1_FIFO_SLAVE_WAIT_EN
  // Wait-state down-counter, loaded on leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // FIFO state only moves at the closing RESP edge of a still-valid, good request.
  assign commit = (state_q == RESP) && valid && !err_q;
  assign push   = commit && write;
  assign pop    = commit && !write;

  comp1_fifo_slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (data_wr),
    .rdata (head_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready   = (state_q == RESP);
  assign data_rd = data_rd_q;
  assign err     = err_q;
  assign full    = fifo_full;
  assign empty   = fifo_empty;

endmodule

// File: tb/tb_comp1_fifo_slave.sv
// tb_comp1_fifo_slave: directed self-checking bench for comp1_fifo_slave with
// DEPTH=4 and WAIT_CYC=2; expected latency follows COMP1_FIFO_SLAVE_WAIT_EN.
module tb_comp1_fifo_slave;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef COMP1_FIFO_SLAVE_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              ready;
  logic              write;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;
  logic              err;
  logic [2:0]        level;
  logic              full;
  logic              empty;

  int tests;
  int failed;

  comp1_fifo_slave #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .WAIT_CYC (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .ready   (ready),
    .write   (write),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .err     (err),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on a miss count the failure and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request and hold it until the ready pulse closes; report the
  // number of edges to ready (0 on timeout), response data/err, and ready
  // after the transfer edge.
  task automatic applyStimulus(input logic w, input logic [31:0] d,
                               output int lat, output logic [31:0] rd,
                               output logic er, output logic rdy_after);
    bit got;
    valid   = 1'b1;
    write   = w;
    data_wr = d;
    lat     = 0;
    got     = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        got = 1'b1;
        lat = k;
      end
    end
    rd = data_rd;
    er = err;
    if (got) begin
      @(posedge clk);
      #1;
    end
    rdy_after = ready;
    valid     = 1'b0;
    write     = 1'b0;
    data_wr   = '0;
  endtask

  // Full transaction with every response field checked against hand values.
  task automatic doTxn(input string tag, input logic w, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_level);
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        rdy_after;
    applyStimulus(w, d, lat, rd, er, rdy_after);
    checkOutput({tag, " latency"}, 32'(lat), 32'(EXP_WAIT + 1));
    checkOutput({tag, " data_rd"}, rd, exp_rd);
    checkOutput({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
    checkOutput({tag, " ready low after"}, {31'd0, rdy_after}, 32'd0);
    checkOutput({tag, " level"}, {29'd0, level}, 32'(exp_level));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    tests   = 0;
    failed  = 0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    write   = 1'b0;
    data_wr = '0;

    // Reset values while held in reset and after release with no requests.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", {31'd0, ready}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset data_rd", data_rd, 32'd0);
    checkOutput("reset level", {29'd0, level}, 32'd0);
    checkOutput("reset full", {31'd0, full}, 32'd0);
    checkOutput("reset empty", {31'd0, empty}, 32'd1);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | ready;
    end
    checkOutput("idle no ready", {31'd0, seen}, 32'd0);
    checkOutput("idle empty", {31'd0, empty}, 32'd1);

    // Single push then pop.
    doTxn("push A5A50001", 1'b1, 32'hA5A5_0001, 32'h0, 1'b0, 1);
    doTxn("pop A5A50001", 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 0);

    // Fill past capacity: fifth push overflows.
    doTxn("fill 0", 1'b1, 32'hB0, 32'h0, 1'b0, 1);
    doTxn("fill 1", 1'b1, 32'hB1, 32'h0, 1'b0, 2);
    doTxn("fill 2", 1'b1, 32'hB2, 32'h0, 1'b0, 3);
    doTxn("fill 3", 1'b1, 32'hB3, 32'h0, 1'b0, 4);
    checkOutput("full after 4", {31'd0, full}, 32'd1);
    doTxn("overflow", 1'b1, 32'hB4, 32'h0, 1'b1, 4);
    checkOutput("full after overflow", {31'd0, full}, 32'd1);

    // Drain past empty: fifth pop underflows with zero data.
    doTxn("drain 0", 1'b0, 32'h0, 32'hB0, 1'b0, 3);
    doTxn("drain 1", 1'b0, 32'h0, 32'hB1, 1'b0, 2);
    doTxn("drain 2", 1'b0, 32'h0, 32'hB2, 1'b0, 1);
    doTxn("drain 3", 1'b0, 32'h0, 32'hB3, 1'b0, 0);
    doTxn("underflow", 1'b0, 32'h0, 32'h0, 1'b1, 0);
    checkOutput("empty after underflow", {31'd0, empty}, 32'd1);

    // Interleaved pairs walk both pointers around the ring.
    for (int i = 0; i < 10; i++) begin
      doTxn($sformatf("wrap push %0d", i), 1'b1, 32'h10 + 32'(i), 32'h0, 1'b0, 1);
      doTxn($sformatf("wrap pop %0d", i), 1'b0, 32'h0, 32'h10 + 32'(i), 1'b0, 0);
    end

    // Abandoned request: valid dropped one edge after being sampled.
    doTxn("pre-abort push", 1'b1, 32'h77, 32'h0, 1'b0, 1);
    valid   = 1'b1;
    write   = 1'b1;
    data_wr = 32'hDEAD;
    @(posedge clk);
    #1;
    seen    = ready;
    valid   = 1'b0;
    write   = 1'b0;
    data_wr = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | ready;
    end
    checkOutput("abort ready seen", {31'd0, seen}, {31'd0, EXP_WAIT == 0});
    checkOutput("abort level", {29'd0, level}, 32'd1);
    doTxn("post-abort pop", 1'b0, 32'h0, 32'h77, 1'b0, 0);

    // Reset in the middle of a pop with three entries stored.
    doTxn("pre-reset push 0", 1'b1, 32'h31, 32'h0, 1'b0, 1);
    doTxn("pre-reset push 1", 1'b1, 32'h32, 32'h0, 1'b0, 2);
    doTxn("pre-reset push 2", 1'b1, 32'h33, 32'h0, 1'b0, 3);
    valid = 1'b1;
    write = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset ready", {31'd0, ready}, 32'd0);
    checkOutput("mid-reset level", {29'd0, level}, 32'd0);
    valid = 1'b0;
    seen  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen = seen | ready;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | ready;
    end
    checkOutput("reset no ready", {31'd0, seen}, 32'd0);
    checkOutput("post-reset level", {29'd0, level}, 32'd0);
    checkOutput("post-reset empty", {31'd0, empty}, 32'd1);
    doTxn("post-reset pop", 1'b0, 32'h0, 32'h0, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
